// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the core MEM stage and the data memory.
// The slave modport is the memory side; the master modport is the core side.
interface data_memory_ctrl_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        input  rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport master (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        output rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressable RV32I data memory with valid/ready handshake, load extension,
// lane-preserving sub-word stores, error flagging, wait states and a post-reset clear sweep.
module data_memory_ctrl #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned WAIT_STATES = 0
) (
    input logic               clk_i,
    input logic               reset_i,
    data_memory_ctrl_if.slave bus
);
    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [32:0] BYTE_SPAN  = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WAIT_INIT  = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [1:0]       state_q;
    logic [IDX_W-1:0] clr_idx_q;
    logic [3:0]       cnt_q;

    logic        we_q, uns_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept, access;
    logic        a_we, a_uns, a_err;
    logic [1:0]  a_size, lane;
    logic [31:0] a_addr, a_wdata, offset;
    logic [IDX_W-1:0] a_idx;
    logic [31:0] rd_word, ld_data, st_word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign accept = !reset_i && state_q == ST_IDLE && bus.req_valid_i;
    assign access = !reset_i && ((accept && WAIT_STATES == 0) || (state_q == ST_WAIT && cnt_q == 4'd0));

    // With zero wait states the access happens on the acceptance edge, so the live request is used.
    assign a_we    = (state_q == ST_IDLE) ? bus.req_we_i       : we_q;
    assign a_uns   = (state_q == ST_IDLE) ? bus.req_unsigned_i : uns_q;
    assign a_size  = (state_q == ST_IDLE) ? bus.req_size_i     : size_q;
    assign a_addr  = (state_q == ST_IDLE) ? bus.req_addr_i     : addr_q;
    assign a_wdata = (state_q == ST_IDLE) ? bus.req_wdata_i    : wdata_q;

    assign offset = a_addr - BASE_ADDR;
    assign a_idx  = offset[IDX_W+1:2];
    assign lane   = a_addr[1:0];
    assign a_err  = (a_size == 2'b11)
                 || (a_size == 2'b01 && a_addr[0])
                 || (a_size == 2'b10 && a_addr[1:0] != 2'b00)
                 || (a_addr < BASE_ADDR)
                 || ({1'b0, offset} >= BYTE_SPAN);

    always_comb begin
        rd_word = mem[a_idx];
        ld_byte = rd_word[{lane, 3'b000} +: 8];
        ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (a_size)
            2'b00:   ld_data = {{24{ld_byte[7] & ~a_uns}}, ld_byte};
            2'b01:   ld_data = {{16{ld_half[15] & ~a_uns}}, ld_half};
            default: ld_data = rd_word;
        endcase
        st_word = rd_word;
        case (a_size)
            2'b00:   st_word[{lane, 3'b000} +: 8]       = a_wdata[7:0];
            2'b01:   st_word[{lane[1], 4'b0000} +: 16]  = a_wdata[15:0];
            default: st_word = a_wdata;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && state_q == ST_CLEAR) begin
            mem[clr_idx_q] <= '0;
        end else if (access && a_we && !a_err) begin
            mem[a_idx] <= st_word;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            size_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_idx_q <= clr_idx_q + 1'b1;
                    if (&clr_idx_q) state_q <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (accept) begin
                        we_q    <= bus.req_we_i;
                        uns_q   <= bus.req_unsigned_i;
                        size_q  <= bus.req_size_i;
                        addr_q  <= bus.req_addr_i;
                        wdata_q <= bus.req_wdata_i;
                        if (WAIT_STATES == 0) begin
                            state_q <= ST_RESP;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= WAIT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd0) state_q <= ST_RESP;
                    else               cnt_q   <= cnt_q - 1'b1;
                end
                default: begin
                    if (bus.rsp_ready_i) state_q <= ST_IDLE;
                end
            endcase
            if (access) begin
                rdata_q <= (a_we || a_err) ? '0 : ld_data;
                err_q   <= a_err;
            end
        end
    end

    assign bus.req_ready_o = !reset_i && state_q == ST_IDLE;
    assign bus.rsp_valid_o = !reset_i && state_q == ST_RESP;
    assign bus.rsp_rdata_o = reset_i ? '0 : rdata_q;
    assign bus.rsp_err_o   = !reset_i && err_q;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: two instances (0 and 3 wait states) share one driver and
// are checked against a byte-array reference model with directed and random traffic.
module tb_data_memory_ctrl;
    logic clk = 1'b0;
    logic reset_i = 1'b1;
    always #5 clk = ~clk;

    data_memory_ctrl_if if0 ();
    data_memory_ctrl_if if1 ();

    data_memory_ctrl #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0), .WAIT_STATES(0))
        dut0 (.clk_i(clk), .reset_i(reset_i), .bus(if0));
    data_memory_ctrl #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0), .WAIT_STATES(3))
        dut1 (.clk_i(clk), .reset_i(reset_i), .bus(if1));

    logic        sel = 1'b0;
    logic        req_valid = 1'b0, we = 1'b0, uns = 1'b0, rsp_ready = 1'b0;
    logic [1:0]  size = 2'b10;
    logic [31:0] addr = '0, wdata = '0;

    assign if0.req_valid_i = req_valid && !sel;
    assign if1.req_valid_i = req_valid && sel;
    assign if0.rsp_ready_i = rsp_ready && !sel;
    assign if1.rsp_ready_i = rsp_ready && sel;
    assign if0.req_we_i = we;        assign if1.req_we_i = we;
    assign if0.req_size_i = size;    assign if1.req_size_i = size;
    assign if0.req_unsigned_i = uns; assign if1.req_unsigned_i = uns;
    assign if0.req_addr_i = addr;    assign if1.req_addr_i = addr;
    assign if0.req_wdata_i = wdata;  assign if1.req_wdata_i = wdata;

    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    assign req_ready = sel ? if1.req_ready_o : if0.req_ready_o;
    assign rsp_valid = sel ? if1.rsp_valid_o : if0.rsp_valid_o;
    assign rsp_rdata = sel ? if1.rsp_rdata_o : if0.rsp_rdata_o;
    assign rsp_err   = sel ? if1.rsp_err_o   : if0.rsp_err_o;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;
    logic [7:0]  model_mem [2][1024];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: memory is a flat byte array, accesses are little-endian runs of 1/2/4 bytes.
    function automatic void model_op(input int s, input logic w, input logic [1:0] sz, input logic u,
                                     input logic [31:0] a, input logic [31:0] d,
                                     output logic [31:0] rd, output logic er);
        int unsigned nbytes;
        logic [31:0] v;
        nbytes = 1 << sz;
        er = (sz == 2'b11) || (a >= 32'd1024) || ((a % nbytes) != 0);
        rd = '0;
        if (er) return;
        if (w) begin
            for (int unsigned b = 0; b < nbytes; b++) model_mem[s][a + b] = 8'(d >> (8 * b));
        end else begin
            v = '0;
            for (int unsigned b = 0; b < nbytes; b++) v = v | (32'(model_mem[s][a + b]) << (8 * b));
            if (!u && nbytes < 4 && v[8 * nbytes - 1]) v = v | (32'hFFFF_FFFF << (8 * nbytes));
            rd = v;
        end
    endfunction

    task automatic txn(input logic s, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d, input int hold, input bit abort,
                       output logic [31:0] rd, output logic er);
        int guard;
        int lat;
        logic [31:0] erd;
        logic eer;
        sel = s; we = w; size = sz; uns = u; addr = a; wdata = d; req_valid = 1'b1;
        rd = '0; er = 1'b0;
        guard = 0;
        while (!req_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        model_op(int'(s), w, sz, u, a, d, erd, eer);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), s ? 32'd4 : 32'd1);
        rd = rsp_rdata;
        er = rsp_err;
        check("rdata", rd, erd);
        check("err", 32'(er), 32'(eer));
        if (abort) return;
        for (int i = 0; i < hold; i++) begin
            check("hold_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, rd);
            check("hold_err", 32'(rsp_err), 32'(er));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_drop", 32'(rsp_valid), 32'd0);
    endtask

    task automatic do_reset(input int n);
        int cyc;
        reset_i = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("rst_ready", 32'({if1.req_ready_o, if0.req_ready_o}), 32'd0);
            check("rst_valid", 32'({if1.rsp_valid_o, if0.rsp_valid_o}), 32'd0);
            check("rst_rdata", if0.rsp_rdata_o | if1.rsp_rdata_o, 32'd0);
            check("rst_err", 32'({if1.rsp_err_o, if0.rsp_err_o}), 32'd0);
        end
        for (int s = 0; s < 2; s++)
            for (int unsigned b = 0; b < 1024; b++) model_mem[s][b] = 8'h00;
        reset_i = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end while (!if0.req_ready_o && cyc < 1000);
        check("clear_cycles", 32'(cyc), 32'd256);
        check("clear_ready1", 32'(if1.req_ready_o), 32'd1);
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        @(negedge clk);
        // Power-up reset and sweep, then first load
        do_reset(3);
        txn(0, 0, 2'b10, 0, 32'h0, '0, 0, 0, rd, er);
        check("t1_lw0", rd, 32'h0);
        check("t1_err", 32'(er), 32'd0);

        // Loads with extension
        txn(0, 1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, 1, 0, rd, er);
        txn(0, 0, 2'b00, 0, 32'h11, '0, 0, 0, rd, er);  check("t2_lb",  rd, 32'hFFFF_FFBE);
        txn(0, 0, 2'b00, 1, 32'h13, '0, 0, 0, rd, er);  check("t2_lbu", rd, 32'h0000_00DE);
        txn(0, 0, 2'b01, 0, 32'h12, '0, 0, 0, rd, er);  check("t2_lh",  rd, 32'hFFFF_DEAD);
        txn(0, 0, 2'b01, 1, 32'h10, '0, 0, 0, rd, er);  check("t2_lhu", rd, 32'h0000_BEEF);

        // Sub-word stores keep the other lanes
        txn(0, 1, 2'b00, 0, 32'h12, 32'h0000_0055, 0, 0, rd, er);
        txn(0, 0, 2'b10, 0, 32'h10, '0, 0, 0, rd, er);  check("t3_sb", rd, 32'hDE55_BEEF);
        txn(0, 1, 2'b01, 0, 32'h10, 32'h0000_1234, 0, 0, rd, er);
        txn(0, 0, 2'b10, 0, 32'h10, '0, 0, 0, rd, er);  check("t3_sh", rd, 32'hDE55_1234);

        // Error cases
        txn(0, 0, 2'b10, 0, 32'h11, '0, 0, 0, rd, er);
        check("t4_mis_err", 32'(er), 32'd1);            check("t4_mis_rd", rd, 32'h0);
        txn(0, 1, 2'b10, 0, 32'h12, 32'hFFFF_FFFF, 0, 0, rd, er);
        check("t4_sw_err", 32'(er), 32'd1);
        txn(0, 0, 2'b10, 0, 32'h10, '0, 0, 0, rd, er);  check("t4_unchanged", rd, 32'hDE55_1234);
        txn(0, 0, 2'b10, 0, 32'h400, '0, 0, 0, rd, er); check("t4_range_err", 32'(er), 32'd1);
        txn(0, 0, 2'b11, 0, 32'h10, '0, 0, 0, rd, er);  check("t4_size_err", 32'(er), 32'd1);

        // Wait states and a long response stall
        txn(1, 1, 2'b10, 0, 32'h40, 32'h1357_9BDF, 0, 0, rd, er);
        txn(1, 0, 2'b10, 0, 32'h40, '0, 5, 0, rd, er);  check("t5_lw", rd, 32'h1357_9BDF);

        // Random traffic concentrated on a small window so loads hit earlier stores
        for (int i = 0; i < 80; i++) begin
            logic        s, w, u;
            logic [1:0]  sz;
            logic [31:0] a, d;
            int unsigned r;
            s  = 1'(i % 2);
            w  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 9);
            sz = (r < 9) ? 2'(r % 3) : 2'b11;
            r  = $urandom_range(0, 9);
            if (r < 7)      a = 32'($urandom_range(0, 63)) & ~((32'd1 << sz) - 1);
            else if (r < 8) a = 32'($urandom_range(0, 63));
            else if (r < 9) a = 32'($urandom_range(960, 1023)) & ~32'd3;
            else            a = 32'd1024 + 32'($urandom_range(0, 4096));
            d  = $urandom;
            txn(s, w, sz, u, a, d, int'($urandom_range(0, 2)), 0, rd, er);
        end

        // Reset while a response is pending restarts the sweep
        txn(0, 1, 2'b10, 0, 32'h20, 32'hA5A5_A5A5, 0, 1, rd, er);
        reset_i = 1'b1;
        @(negedge clk);
        check("t6_valid_drop", 32'(if0.rsp_valid_o), 32'd0);
        do_reset(1);
        txn(0, 0, 2'b10, 0, 32'h20, '0, 0, 0, rd, er);  check("t6_lw", rd, 32'h0);
        txn(1, 0, 2'b10, 0, 32'h40, '0, 0, 0, rd, er);  check("t6_lw_ws", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end
endmodule
